perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised bank of hardware performance counters for the core's debug and performance infrastructure. It replaces per-signal ad-hoc counters with a single multi-channel block. Each channel accepts a multi-bit increment per cycle and supports wrap or saturate on overflow, with sticky overflow flags. A global snapshot, a read-and-clear path and per-channel threshold pulses let log and trace logic sample all counters coherently.

## Interface
Parameters:
- NUM_EVENTS, 8, number of counter channels (≥1)
- CNT_WIDTH, 32, width of each counter and snapshot register
- EVT_WIDTH, 2, width of per-channel increment (max increment 2^EVT_WIDTH-1 per cycle)
- IDX_WIDTH, $clog2(NUM_EVENTS) (min 1), read index width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  global count enable; increments ignored when 0
- evt_inc  in  NUM_EVENTS*EVT_WIDTH  channel i increment at bits [i*EVT_WIDTH +: EVT_WIDTH]
- mode_sat  in  1  1 = saturate at all-ones, 0 = wrap modulo 2^CNT_WIDTH
- clear  in  1  zero all live counters and overflow flags
- snap  in  1  copy all live counters into the snapshot bank
- thresh  in  CNT_WIDTH  threshold shared by all channels
- rd_req  in  1  read request
- rd_idx  in  IDX_WIDTH  channel to read; out-of-range indices return zeros
- rd_valid  out  1  read response valid, one cycle
- rd_data  out  CNT_WIDTH  snapshot value of requested channel
- rd_ovf  out  1  overflow flag of requested channel, sampled with rd_data
- ovf  out  NUM_EVENTS  sticky per-channel overflow flags
- thresh_hit  out  NUM_EVENTS  one-cycle per-channel threshold-crossing pulse

## Operation
- Per-channel state: cnt[i] (CNT_WIDTH), snap_r[i] (CNT_WIDTH), ovf[i].
- Sum: sum = {1'b0,cnt[i]} + inc[i], CNT_WIDTH+1 bits. carry = sum[CNT_WIDTH].
- No carry: cnt[i] <= sum[CNT_WIDTH-1:0].
- Carry, mode_sat=0: cnt[i] <= sum[CNT_WIDTH-1:0]; ovf[i] <= 1.
- Carry, mode_sat=1: cnt[i] <= all-ones; ovf[i] <= 1.
- A saturated counter stays all-ones. Further nonzero increments re-assert ovf, which is already set.
- Counting occurs only when en=1. inc=0 or en=0 leaves cnt and ovf unchanged.
- Priority per cycle: rst > clear > count.
  - clear zeroes cnt and ovf. Increments presented in the clear cycle are dropped.
- snap: snap_r[i] <= cnt[i], using the pre-update value of that cycle.
  - snap+clear in the same cycle is read-and-clear: the snapshot holds the pre-clear values and the counters become 0.
  - snap with counting: the snapshot excludes that cycle's increment.
- Threshold pulse: thresh_hit[i] <= en && !clear && thresh!=0 && ((cnt[i] < thresh && new[i] >= thresh) || (carry && new[i] >= thresh)).
  - new[i] is the value written this cycle.
  - thresh=0 never fires.
- Read: a rd_req sampled at edge T produces rd_valid=1 for exactly the cycle after T.
  - rd_data = snap_r[rd_idx] and rd_ovf = ovf[rd_idx], both as held before edge T's updates.
  - A snap in the request cycle is therefore not visible; back-to-back requests are each served, one per cycle.
  - With rd_req=0, rd_valid=0 and rd_data/rd_ovf hold their last value.
- No backpressure: the consumer must accept rd_valid when it is asserted.

## Timing
- All state is registered on posedge clk. Outputs are driven directly from flops; there is no combinational input-to-output path.
- Reset: in the cycle after rst is sampled high, all cnt, snap_r, ovf, thresh_hit, rd_valid, rd_data and rd_ovf are 0.
  - Reset asserted mid-read suppresses rd_valid in the following cycle.
- Counter latency: an increment presented at edge T is visible in cnt, ovf and thresh_hit after T.
- Read latency: 1 cycle, throughput 1 read per cycle.
- Simultaneous clear and thresh crossing: clear wins and no pulse is produced.
- Boundary: cnt = 2^CNT_WIDTH-1 with inc=0 sets no overflow.

## Test plan
- Reset then count: NUM_EVENTS=8, CNT_WIDTH=8, en=1, channel 0 inc=1 for 10 cycles, snap, read idx 0 -> rd_valid one cycle later, rd_data=10, rd_ovf=0.
- Wrap: CNT_WIDTH=8, mode_sat=0, channel 3 preloaded to 254 via counting, inc=3 -> cnt=1, ovf[3]=1 sticky until clear.
- Saturate: mode_sat=1, cnt=254, inc=3 -> cnt=255, ovf=1; a further 5 increments keep cnt=255.
- Read-and-clear: cnt[2]=40, snap+clear in the same cycle with inc=2 -> snap_r[2]=40, cnt[2]=0, ovf cleared, increment dropped.
- Threshold: thresh=16, channel 1 at 15, inc=2 -> thresh_hit[1] pulses exactly one cycle and does not fire again at 19. thresh=0 never pulses.
- Read corner cases:
  - rd_req with rd_idx=9 (out of range) -> rd_data=0, rd_ovf=0.
  - Back-to-back requests idx 0, 1, 2 -> three consecutive rd_valid cycles with matching data.
  - rst during a request -> no rd_valid.

Source files
------------

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - multi-channel performance counter bank with snapshot and read-and-clear
module perf_counter_bank #(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int EVT_WIDTH  = 2,
  parameter int IDX_WIDTH  = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic [NUM_EVENTS*EVT_WIDTH-1:0] evt_inc_i,
  input  logic                            mode_sat_i,
  input  logic                            clear_i,
  input  logic                            snap_i,
  input  logic [CNT_WIDTH-1:0]            thresh_i,
  input  logic                            rd_req_i,
  input  logic [IDX_WIDTH-1:0]            rd_idx_i,
  output logic                            rd_valid_o,
  output logic [CNT_WIDTH-1:0]            rd_data_o,
  output logic                            rd_ovf_o,
  output logic [NUM_EVENTS-1:0]           ovf_o,
  output logic [NUM_EVENTS-1:0]           thresh_hit_o
);

  logic [CNT_WIDTH-1:0]  cnt_q  [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  cnt_d  [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  snap_q [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] ovf_q, ovf_d;
  logic [NUM_EVENTS-1:0] hit_q, hit_d;
  logic                  rd_valid_q;
  logic [CNT_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                  rd_ovf_q, rd_ovf_d;

  logic [EVT_WIDTH-1:0]  inc;
  logic [CNT_WIDTH:0]    sum;
  logic                  carry;
  logic [CNT_WIDTH-1:0]  nxt;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    hit_d = '0;
    inc   = '0;
    sum   = '0;
    carry = 1'b0;
    nxt   = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      inc   = evt_inc_i[i*EVT_WIDTH +: EVT_WIDTH];
      sum   = {1'b0, cnt_q[i]} + (CNT_WIDTH+1)'(inc);
      carry = sum[CNT_WIDTH];
      nxt   = (carry && mode_sat_i) ? '1 : sum[CNT_WIDTH-1:0];
      // clear drops the cycle's increments and suppresses any threshold pulse
      if (clear_i) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (en_i) begin
        cnt_d[i] = nxt;
        if (carry) begin
          ovf_d[i] = 1'b1;
        end
        hit_d[i] = (thresh_i != '0) && (nxt >= thresh_i) &&
                   ((cnt_q[i] < thresh_i) || carry);
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    for (int j = 0; j < NUM_EVENTS; j++) begin
      if (rd_idx_i == IDX_WIDTH'(j)) begin
        rd_data_d = snap_q[j];
        rd_ovf_d  = ovf_q[j];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      ovf_q      <= '0;
      hit_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      hit_q      <= hit_d;
      rd_valid_q <= rd_req_i;
      // snapshot takes pre-update counts, so snap+clear acts as read-and-clear
      if (snap_i) begin
        snap_q <= cnt_q;
      end
      if (rd_req_i) begin
        rd_data_q <= rd_data_d;
        rd_ovf_q  <= rd_ovf_d;
      end
    end
  end

  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign rd_ovf_o     = rd_ovf_q;
  assign ovf_o        = ovf_q;
  assign thresh_hit_o = hit_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - scoreboard bench for perf_counter_bank
module tb_perf_counter_bank;
  localparam int N  = 8;
  localparam int CW = 8;
  localparam int EW = 2;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst, en, mode_sat, clear, snap, rd_req;
  logic [N*EW-1:0] evt_inc;
  logic [CW-1:0]   thresh;
  logic [IW-1:0]   rd_idx;
  logic            rd_valid, rd_ovf;
  logic [CW-1:0]   rd_data;
  logic [N-1:0]    ovf, thresh_hit;

  typedef struct {
    logic [CW-1:0] d;
    logic          o;
    int            due;
  } rsp_t;
  rsp_t q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  perf_counter_bank #(.NUM_EVENTS(N), .CNT_WIDTH(CW), .EVT_WIDTH(EW), .IDX_WIDTH(IW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .evt_inc_i(evt_inc), .mode_sat_i(mode_sat),
    .clear_i(clear), .snap_i(snap), .thresh_i(thresh), .rd_req_i(rd_req), .rd_idx_i(rd_idx),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_ovf_o(rd_ovf), .ovf_o(ovf),
    .thresh_hit_o(thresh_hit)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid must match the oldest expected response, on its due cycle
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 at cycle %0d expected none", cyc);
      end else begin
        rsp_t e;
        e = q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e.d));
        chk("rd_ovf", 32'(rd_ovf), 32'(e.o));
        chk("rd_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count(input int ch, input int v, input int n);
    evt_inc[ch*EW +: EW] = v[EW-1:0];
    repeat (n) tick();
    evt_inc = '0;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic rd(input int idx, input logic [CW-1:0] d, input logic o);
    rsp_t e;
    e.d = d;
    e.o = o;
    e.due = cyc + 1;
    q.push_back(e);
    rd_req = 1'b1;
    rd_idx = idx[IW-1:0];
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode_sat = 1'b0; clear = 1'b0; snap = 1'b0;
    rd_req = 1'b0; rd_idx = '0; evt_inc = '0; thresh = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_ovf", 32'(ovf), 32'h0);
    chk("reset_hit", 32'(thresh_hit), 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    rd(0, 8'd0, 1'b0);

    // basic count
    en = 1'b1;
    count(0, 1, 10);
    do_snap();
    rd(0, 8'd10, 1'b0);

    // wrap: 252 + 2 = 254, then +3 -> 1 with overflow
    count(3, 3, 84);
    count(3, 2, 1);
    count(3, 3, 1);
    chk("wrap_ovf", 32'(ovf[3]), 32'h1);
    count(3, 0, 3);
    chk("wrap_ovf_sticky", 32'(ovf[3]), 32'h1);
    do_snap();
    rd(3, 8'd1, 1'b1);
    do_clear();
    chk("clear_ovf", 32'(ovf), 32'h0);

    // saturate
    mode_sat = 1'b1;
    count(4, 3, 84);
    count(4, 2, 1);
    count(4, 3, 1);
    chk("sat_ovf", 32'(ovf[4]), 32'h1);
    count(4, 3, 5);
    do_snap();
    rd(4, 8'hFF, 1'b1);
    do_clear();
    mode_sat = 1'b0;

    // all-ones without further increment: no overflow
    count(5, 3, 85);
    count(5, 0, 2);
    chk("allones_no_ovf", 32'(ovf[5]), 32'h0);
    do_snap();
    rd(5, 8'hFF, 1'b0);

    // read-and-clear with a dropped increment
    do_clear();
    count(2, 2, 20);
    evt_inc[2*EW +: EW] = 2'd2;
    snap = 1'b1;
    clear = 1'b1;
    tick();
    snap = 1'b0; clear = 1'b0; evt_inc = '0;
    rd(2, 8'd40, 1'b0);
    do_snap();
    rd(2, 8'd0, 1'b0);

    // threshold crossing
    thresh = 8'd16;
    do_clear();
    count(1, 3, 5);
    chk("thresh_below", 32'(thresh_hit), 32'h0);
    count(1, 2, 1);
    chk("thresh_pulse", 32'(thresh_hit), 32'h2);
    count(1, 2, 1);
    chk("thresh_no_refire", 32'(thresh_hit), 32'h0);

    // clear wins over a crossing
    do_clear();
    count(1, 3, 5);
    evt_inc[1*EW +: EW] = 2'd2;
    clear = 1'b1;
    tick();
    clear = 1'b0; evt_inc = '0;
    chk("thresh_clear_wins", 32'(thresh_hit), 32'h0);

    // thresh = 0 never fires
    thresh = '0;
    evt_inc[1*EW +: EW] = 2'd3;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("thresh_zero", 32'(thresh_hit), 32'h0);
    end
    evt_inc = '0;

    // back-to-back reads and out-of-range index
    do_clear();
    evt_inc[0*EW +: EW] = 2'd1;
    evt_inc[1*EW +: EW] = 2'd2;
    evt_inc[2*EW +: EW] = 2'd3;
    repeat (3) tick();
    evt_inc = '0;
    do_snap();
    rd(0, 8'd3, 1'b0);
    rd(1, 8'd6, 1'b0);
    rd(2, 8'd9, 1'b0);
    rd(9, 8'd0, 1'b0);
    tick();

    // reset during a request suppresses the response
    rd_req = 1'b1;
    rd_idx = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_req = 1'b0;
    tick(); tick();
    rd(0, 8'd0, 1'b0);
    tick(); tick();
    chk("scoreboard_drained", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
